gnrl_fifo: RTL and testbench

- Parametrised synchronous FIFO with valid/ready handshakes on both sides, built from the team's general DFF primitives.
- Intended as the standard decoupling buffer between pipeline stages: IFU→EXU instruction queue, LSU outstanding-request queue, bus response buffering.
- Generalises the single-register DFF to DP entries of DW bits, adding flow control, a ready-path cut option, output masking and flush.

---
 rtl/gnrl_dffs.sv | 59 +++++
 rtl/gnrl_fifo.sv | 101 ++++++++++
 tb/tb_gnrl_fifo.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gnrl_dffs.sv
// General DFF primitives: load-enable (no reset), reset-to-zero, and
// reset-to-zero with enable.

module gnrl_dffl #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          ld_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);
  logic [DW-1:0] dat_q;

  // Capture on load; storage carries no reset.
  always_ff @(posedge clk) begin
    if (ld_i) dat_q <= d_i;
  end

  assign q_o = dat_q;
endmodule

module gnrl_dffr #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);
  logic [DW-1:0] dat_q;

  // Free-running register, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) dat_q <= '0;
    else        dat_q <= d_i;
  end

  assign q_o = dat_q;
endmodule

module gnrl_dffer #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] q_o
);
  logic [DW-1:0] dat_q;

  // Register holds its value unless en_i is high; asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    dat_q <= '0;
    else if (en_i) dat_q <= d_i;
  end

  assign q_o = dat_q;
endmodule

// File: rtl/gnrl_fifo.sv
// Synchronous valid/ready FIFO built from the general DFF primitives.
// Occupancy counter drives full/empty; no fall-through (1-cycle minimum
// latency). CUT_READY removes the o_rdy->i_rdy path, MSKO zeroes o_dat
// while nothing is valid.

module gnrl_fifo #(
  parameter int DW        = 32,
  parameter int DP        = 4,
  parameter int CUT_READY = 0,
  parameter int MSKO      = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     i_vld,
  output logic                     i_rdy,
  input  logic [DW-1:0]            i_dat,
  output logic                     o_vld,
  input  logic                     o_rdy,
  output logic [DW-1:0]            o_dat,
  output logic [$clog2(DP+1)-1:0]  o_cnt,
  output logic                     full,
  output logic                     empty
);
  localparam int PW = (DP > 1) ? $clog2(DP) : 1;
  localparam int CW = $clog2(DP+1);

  logic                   push, pop;
  logic [PW-1:0]          wptr_q, rptr_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [DP-1:0][DW-1:0]  mem;
  logic [DW-1:0]          head;

  assign full  = (cnt_q == CW'(DP));
  assign empty = (cnt_q == '0);
  assign o_vld = ~empty;
  assign o_cnt = cnt_q;

  // When full, the cut variant refuses outright; otherwise a same-cycle
  // pop frees the slot being written.
  assign i_rdy = (CUT_READY != 0) ? ~full : (~full | o_rdy);
  assign push  = i_vld & i_rdy;
  assign pop   = o_vld & o_rdy;

  // Pointers: single-entry buffer needs none.
  if (DP == 1) begin : g_ptr_tie
    assign wptr_q = '0;
    assign rptr_q = '0;
  end else begin : g_ptr
    logic [PW-1:0] wptr_d, rptr_d;

    // Advance with wrap at DP-1; flush returns both pointers to zero.
    always_comb begin
      wptr_d = (wptr_q == PW'(DP-1)) ? '0 : wptr_q + PW'(1);
      rptr_d = (rptr_q == PW'(DP-1)) ? '0 : rptr_q + PW'(1);
      if (flush) begin
        wptr_d = '0;
        rptr_d = '0;
      end
    end

    gnrl_dffer #(.DW(PW)) u_wptr (
      .clk(clk), .rst_n(rst_n), .en_i(push | flush), .d_i(wptr_d), .q_o(wptr_q)
    );
    gnrl_dffer #(.DW(PW)) u_rptr (
      .clk(clk), .rst_n(rst_n), .en_i(pop | flush), .d_i(rptr_d), .q_o(rptr_q)
    );
  end

  // Occupancy: +1 push only, -1 pop only, flush wins over both.
  always_comb begin
    cnt_d = cnt_q;
    if (flush)             cnt_d = '0;
    else if (push && !pop) cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
  end

  gnrl_dffr #(.DW(CW)) u_cnt (
    .clk(clk), .rst_n(rst_n), .d_i(cnt_d), .q_o(cnt_q)
  );

  // Storage: one load-enable register per entry; flushed pushes are dropped.
  for (genvar i = 0; i < DP; i++) begin : g_ent
    gnrl_dffl #(.DW(DW)) u_ent (
      .clk  (clk),
      .ld_i (push & ~flush & (wptr_q == PW'(i))),
      .d_i  (i_dat),
      .q_o  (mem[i])
    );
  end

  // Head-of-queue read mux.
  always_comb begin
    head = '0;
    for (int k = 0; k < DP; k++) begin
      if (rptr_q == PW'(k)) head = mem[k];
    end
  end

  assign o_dat = ((MSKO != 0) && !o_vld) ? '0 : head;
endmodule

// File: tb/tb_gnrl_fifo.sv
// Bench for gnrl_fifo: three configurations (DP=4 plain, DP=4 ready-cut,
// DP=1 masked output) checked against queue-based reference models.

module tb_gnrl_fifo;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // a: DP=4 CUT_READY=0 ; b: DP=4 CUT_READY=1 ; c: DP=1 MSKO=1
  logic       a_flush, a_i_vld, a_i_rdy, a_o_vld, a_o_rdy, a_full, a_empty;
  logic [7:0] a_i_dat, a_o_dat;
  logic [2:0] a_o_cnt;
  logic       b_flush, b_i_vld, b_i_rdy, b_o_vld, b_o_rdy, b_full, b_empty;
  logic [7:0] b_i_dat, b_o_dat;
  logic [2:0] b_o_cnt;
  logic       c_flush, c_i_vld, c_i_rdy, c_o_vld, c_o_rdy, c_full, c_empty;
  logic [7:0] c_i_dat, c_o_dat;
  logic [0:0] c_o_cnt;

  gnrl_fifo #(.DW(8), .DP(4), .CUT_READY(0), .MSKO(0)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush), .i_vld(a_i_vld), .i_rdy(a_i_rdy),
    .i_dat(a_i_dat), .o_vld(a_o_vld), .o_rdy(a_o_rdy), .o_dat(a_o_dat),
    .o_cnt(a_o_cnt), .full(a_full), .empty(a_empty));
  gnrl_fifo #(.DW(8), .DP(4), .CUT_READY(1), .MSKO(0)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .i_vld(b_i_vld), .i_rdy(b_i_rdy),
    .i_dat(b_i_dat), .o_vld(b_o_vld), .o_rdy(b_o_rdy), .o_dat(b_o_dat),
    .o_cnt(b_o_cnt), .full(b_full), .empty(b_empty));
  gnrl_fifo #(.DW(8), .DP(1), .CUT_READY(0), .MSKO(1)) u_c (
    .clk(clk), .rst_n(rst_n), .flush(c_flush), .i_vld(c_i_vld), .i_rdy(c_i_rdy),
    .i_dat(c_i_dat), .o_vld(c_o_vld), .o_rdy(c_o_rdy), .o_dat(c_o_dat),
    .o_cnt(c_o_cnt), .full(c_full), .empty(c_empty));

  int nvec = 0;
  int nerr = 0;

  // Reference contents, oldest first.
  logic [7:0] qa[$];
  logic [7:0] qb[$];
  logic [7:0] qc[$];

  task automatic idle_all();
    a_flush = 0; a_i_vld = 0; a_i_dat = 0; a_o_rdy = 0;
    b_flush = 0; b_i_vld = 0; b_i_dat = 0; b_o_rdy = 0;
    c_flush = 0; c_i_vld = 0; c_i_dat = 0; c_o_rdy = 0;
  endtask

  // Advance one clock; models accept/emit by the handshake rules.
  task automatic tick();
    bit pa, ra, pb, rb, pc, rc;
    logic [7:0] da, db, dc;
    bit fa, fb, fc;
    pa = a_i_vld && ((qa.size() < 4) || a_o_rdy);
    ra = (qa.size() > 0) && a_o_rdy;
    pb = b_i_vld && (qb.size() < 4);
    rb = (qb.size() > 0) && b_o_rdy;
    pc = c_i_vld && ((qc.size() < 1) || c_o_rdy);
    rc = (qc.size() > 0) && c_o_rdy;
    da = a_i_dat; db = b_i_dat; dc = c_i_dat;
    fa = a_flush; fb = b_flush; fc = c_flush;
    @(posedge clk);
    if (fa) qa.delete(); else begin
      if (ra) void'(qa.pop_front());
      if (pa) qa.push_back(da);
    end
    if (fb) qb.delete(); else begin
      if (rb) void'(qb.pop_front());
      if (pb) qb.push_back(db);
    end
    if (fc) qc.delete(); else begin
      if (rc) void'(qc.pop_front());
      if (pc) qc.push_back(dc);
    end
    #1;
  endtask

  task automatic clear_all();
    idle_all();
    a_flush = 1; b_flush = 1; c_flush = 1;
    tick();
    idle_all();
    #1;
  endtask

  task automatic test_reset();
    idle_all();
    rst_n = 0;
    #12;
    nvec++; if (a_o_vld !== 1'b0) begin nerr++; $display("FAIL reset_o_vld got %b exp 0", a_o_vld); end
    nvec++; if (a_i_rdy !== 1'b1) begin nerr++; $display("FAIL reset_i_rdy got %b exp 1", a_i_rdy); end
    nvec++; if (a_empty !== 1'b1 || a_full !== 1'b0) begin nerr++; $display("FAIL reset_flags got e=%b f=%b exp e=1 f=0", a_empty, a_full); end
    nvec++; if (a_o_cnt !== 3'd0 || b_o_cnt !== 3'd0) begin nerr++; $display("FAIL reset_cnt got %0d/%0d exp 0", a_o_cnt, b_o_cnt); end
    nvec++; if (c_o_dat !== 8'h00) begin nerr++; $display("FAIL reset_msko_dat got %h exp 00", c_o_dat); end
    @(negedge clk);
    rst_n = 1;
    qa.delete(); qb.delete(); qc.delete();
    @(posedge clk); #1;
  endtask

  task automatic test_fill_drain();
    clear_all();
    for (int k = 0; k < 4; k++) begin
      a_i_vld = 1; a_i_dat = 8'hA0 + 8'(k); a_o_rdy = 0;
      tick();
    end
    a_i_vld = 0; #1;
    nvec++; if (a_full !== 1'b1 || a_o_cnt !== 3'd4) begin nerr++; $display("FAIL fill_full got f=%b cnt=%0d exp f=1 cnt=4", a_full, a_o_cnt); end
    nvec++; if (a_i_rdy !== 1'b0) begin nerr++; $display("FAIL fill_i_rdy got %b exp 0", a_i_rdy); end
    a_o_rdy = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      nvec++; if (a_o_vld !== 1'b1 || a_o_dat !== 8'hA0 + 8'(k)) begin nerr++; $display("FAIL drain_dat%0d got v=%b %h exp v=1 %h", k, a_o_vld, a_o_dat, 8'hA0 + 8'(k)); end
      tick();
    end
    a_o_rdy = 0; #1;
    nvec++; if (a_empty !== 1'b1 || a_o_vld !== 1'b0) begin nerr++; $display("FAIL drain_empty got e=%b v=%b exp e=1 v=0", a_empty, a_o_vld); end
  endtask

  task automatic test_pass_through();
    logic [7:0] exp_seq [5];
    exp_seq = '{8'hD0, 8'hD1, 8'hD2, 8'hD3, 8'hB0};
    clear_all();
    for (int k = 0; k < 4; k++) begin
      a_i_vld = 1; a_i_dat = 8'hD0 + 8'(k); a_o_rdy = 0;
      tick();
    end
    a_i_vld = 1; a_i_dat = 8'hB0; a_o_rdy = 1; #1;
    nvec++; if (a_i_rdy !== 1'b1) begin nerr++; $display("FAIL pass_i_rdy got %b exp 1", a_i_rdy); end
    tick();
    a_i_vld = 0; #1;
    nvec++; if (a_o_cnt !== 3'd4 || a_full !== 1'b1) begin nerr++; $display("FAIL pass_cnt got %0d exp 4", a_o_cnt); end
    // First pop already consumed D0 during the pass-through cycle.
    for (int k = 1; k < 5; k++) begin
      #1;
      nvec++; if (a_o_dat !== exp_seq[k]) begin nerr++; $display("FAIL pass_order%0d got %h exp %h", k, a_o_dat, exp_seq[k]); end
      tick();
    end
    a_o_rdy = 0; #1;
    nvec++; if (a_empty !== 1'b1) begin nerr++; $display("FAIL pass_empty got %b exp 1", a_empty); end
  endtask

  task automatic test_ready_cut();
    clear_all();
    for (int k = 0; k < 4; k++) begin
      b_i_vld = 1; b_i_dat = 8'h30 + 8'(k); b_o_rdy = 0;
      tick();
    end
    b_i_vld = 1; b_i_dat = 8'hEE; b_o_rdy = 1; #1;
    nvec++; if (b_i_rdy !== 1'b0) begin nerr++; $display("FAIL cut_i_rdy_full got %b exp 0", b_i_rdy); end
    tick();
    b_o_rdy = 0; #1;
    nvec++; if (b_o_cnt !== 3'd3) begin nerr++; $display("FAIL cut_cnt got %0d exp 3", b_o_cnt); end
    nvec++; if (b_i_rdy !== 1'b1) begin nerr++; $display("FAIL cut_i_rdy_next got %b exp 1", b_i_rdy); end
    nvec++; if (b_o_dat !== 8'h31) begin nerr++; $display("FAIL cut_head got %h exp 31", b_o_dat); end
    b_i_vld = 0;
  endtask

  task automatic test_wrap();
    int pushed = 0, popped = 0, cyc = 0;
    clear_all();
    while (popped < 10 && cyc < 300) begin
      a_i_vld = (pushed < 10) && (qa.size() < 3) && ($urandom_range(3) != 0);
      a_i_dat = 8'(pushed);
      a_o_rdy = (qa.size() >= 2 || pushed == 10) ? ($urandom_range(3) != 0) : 1'b0;
      #1;
      nvec++; if (a_o_cnt !== 3'(qa.size()) || a_o_vld !== (qa.size() > 0)) begin nerr++; $display("FAIL wrap_cnt got %0d v=%b exp %0d", a_o_cnt, a_o_vld, qa.size()); end
      if (a_o_vld && a_o_rdy) begin
        nvec++; if (a_o_dat !== 8'(popped)) begin nerr++; $display("FAIL wrap_order got %h exp %h", a_o_dat, 8'(popped)); end
        popped++;
      end
      if (a_i_vld && a_i_rdy) pushed++;
      tick();
      cyc++;
    end
    nvec++; if (popped != 10) begin nerr++; $display("FAIL wrap_timeout got %0d pops exp 10", popped); end
    idle_all();
  endtask

  task automatic test_flush();
    clear_all();
    for (int k = 0; k < 3; k++) begin
      a_i_vld = 1; a_i_dat = 8'h70 + 8'(k);
      tick();
    end
    a_flush = 1; a_i_vld = 1; a_i_dat = 8'hCC; #1;
    nvec++; if (a_i_rdy !== 1'b1) begin nerr++; $display("FAIL flush_i_rdy got %b exp 1", a_i_rdy); end
    tick();
    a_flush = 0; a_i_vld = 0; #1;
    nvec++; if (a_empty !== 1'b1 || a_o_cnt !== 3'd0) begin nerr++; $display("FAIL flush_empty got e=%b cnt=%0d exp e=1 cnt=0", a_empty, a_o_cnt); end
    a_i_vld = 1; a_i_dat = 8'h11;
    tick();
    a_i_vld = 0; a_o_rdy = 1; #1;
    nvec++; if (a_o_dat !== 8'h11 || a_o_cnt !== 3'd1) begin nerr++; $display("FAIL flush_after got %h cnt=%0d exp 11 cnt=1", a_o_dat, a_o_cnt); end
    tick();
    a_o_rdy = 0;
  endtask

  task automatic test_async_reset();
    clear_all();
    a_i_vld = 1; a_i_dat = 8'h55; tick();
    a_i_dat = 8'h56; tick();
    a_i_vld = 0;
    #2 rst_n = 0;
    #1;
    nvec++; if (a_o_vld !== 1'b0 || a_o_cnt !== 3'd0) begin nerr++; $display("FAIL async_rst got v=%b cnt=%0d exp v=0 cnt=0", a_o_vld, a_o_cnt); end
    qa.delete(); qb.delete(); qc.delete();
    #1 rst_n = 1;
    #1;
  endtask

  task automatic test_msko();
    clear_all();
    nvec++; if (c_o_dat !== 8'h00 || c_o_vld !== 1'b0) begin nerr++; $display("FAIL msko_empty got %h v=%b exp 00 v=0", c_o_dat, c_o_vld); end
    c_i_vld = 1; c_i_dat = 8'h05; #1;
    nvec++; if (c_o_vld !== 1'b0) begin nerr++; $display("FAIL msko_nofall got v=%b exp 0", c_o_vld); end
    tick();
    c_i_vld = 0; #1;
    nvec++; if (c_o_dat !== 8'h05 || c_o_vld !== 1'b1 || c_full !== 1'b1) begin nerr++; $display("FAIL msko_push got %h v=%b f=%b exp 05 v=1 f=1", c_o_dat, c_o_vld, c_full); end
    c_o_rdy = 1;
    tick();
    c_o_rdy = 0; #1;
    nvec++; if (c_o_dat !== 8'h00 || c_o_vld !== 1'b0) begin nerr++; $display("FAIL msko_pop got %h v=%b exp 00 v=0", c_o_dat, c_o_vld); end
  endtask

  task automatic test_random();
    clear_all();
    for (int n = 0; n < 400; n++) begin
      a_i_vld = $urandom_range(1); a_o_rdy = $urandom_range(1); a_i_dat = 8'($urandom);
      a_flush = ($urandom_range(40) == 0);
      b_i_vld = $urandom_range(1); b_o_rdy = $urandom_range(1); b_i_dat = 8'($urandom);
      b_flush = ($urandom_range(40) == 0);
      c_i_vld = $urandom_range(1); c_o_rdy = $urandom_range(1); c_i_dat = 8'($urandom);
      c_flush = ($urandom_range(40) == 0);
      #1;
      nvec++;
      if (a_o_cnt !== 3'(qa.size()) || a_i_rdy !== ((qa.size() < 4) || a_o_rdy) ||
          a_full !== (qa.size() == 4) || a_empty !== (qa.size() == 0) ||
          (qa.size() > 0 && a_o_dat !== qa[0])) begin
        nerr++; $display("FAIL rand_a cyc%0d got cnt=%0d rdy=%b dat=%h exp cnt=%0d", n, a_o_cnt, a_i_rdy, a_o_dat, qa.size());
      end
      nvec++;
      if (b_o_cnt !== 3'(qb.size()) || b_i_rdy !== (qb.size() < 4) ||
          b_full !== (qb.size() == 4) || b_empty !== (qb.size() == 0) ||
          (qb.size() > 0 && b_o_dat !== qb[0])) begin
        nerr++; $display("FAIL rand_b cyc%0d got cnt=%0d rdy=%b dat=%h exp cnt=%0d", n, b_o_cnt, b_i_rdy, b_o_dat, qb.size());
      end
      nvec++;
      if (c_o_cnt !== 1'(qc.size()) || c_i_rdy !== ((qc.size() < 1) || c_o_rdy) ||
          c_o_vld !== (qc.size() > 0) ||
          c_o_dat !== ((qc.size() > 0) ? qc[0] : 8'h00)) begin
        nerr++; $display("FAIL rand_c cyc%0d got cnt=%0d rdy=%b dat=%h exp cnt=%0d", n, c_o_cnt, c_i_rdy, c_o_dat, qc.size());
      end
      tick();
    end
    idle_all();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_pass_through();
    test_ready_cut();
    test_wrap();
    test_flush();
    test_async_reset();
    test_msko();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
